i2s_rx_master: RTL and testbench

Parametrised I2S/left-justified capture master for the PCM1808 ADC front end, and the successor to the fixed 24-bit receiver. It generates SCKI, BCK and LRCK from the single system clock and deserialises DOUT into a left/right sample pair. Each completed frame is presented on a valid/ready port to the downstream DSP chain. All logic runs on rising `clk`; no flops are clocked by derived clocks.

---
 rtl/i2s_rx_master.sv | 104 ++++++++++
 tb/tb_i2s_rx_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_master.sv
// PCM1808 capture master: generates SCKI/BCK/LRCK from clk and deserialises DOUT
// into left/right frames on a valid/ready port. Define I2S_RX_OVERRUN_EN for overrun tracking.
module i2s_rx_master #(
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32,
  parameter int BCK_DIV = 4,
  parameter int FMT     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              din,
  output logic              scki,
  output logic              bck,
  output logic              lrck,
  output logic [DATA_W-1:0] left,
  output logic [DATA_W-1:0] right,
  output logic              out_valid,
  input  logic              out_ready
`ifdef I2S_RX_OVERRUN_EN
  ,
  output logic              overrun,
  output logic [7:0]        drop_count,
  input  logic              ovr_clr
`endif
);

  localparam int BDW = $clog2(BCK_DIV);
  localparam int SBW = $clog2(SLOT_W);
  localparam int PSW = BDW + SBW + 1;
  localparam logic [BDW-1:0] HALF     = BDW'(BCK_DIV / 2);
  localparam logic [SBW-1:0] SB_FIRST = SBW'(FMT);
  localparam logic [SBW-1:0] SB_SPAN  = SBW'(DATA_W - 1);

  logic [PSW-1:0]    ps;
  logic [SBW-1:0]    sb, sb_off;
  logic [DATA_W-1:0] sr_l, sr_r;
  logic              strobe, active, last_bit, done, overwrite;

  assign scki   = clk;
  assign bck    = ps[BDW-1];
  assign lrck   = ps[PSW-1];
  assign sb     = ps[BDW+SBW-1:BDW];
  // Offset from the first data bit; bits before the window wrap to a large value.
  assign sb_off   = sb - SB_FIRST;
  assign strobe   = en && (ps[BDW-1:0] == HALF);
  assign active   = strobe && (sb_off <= SB_SPAN);
  assign last_bit = active && lrck && (sb_off == SB_SPAN);
  assign overwrite = done && out_valid && !out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps   <= '0;
      sr_l <= '0;
      sr_r <= '0;
    end else if (!en) begin
      ps   <= '0;
      sr_l <= '0;
      sr_r <= '0;
    end else begin
      ps <= ps + 1'b1;
      if (active && !lrck) sr_l <= {sr_l[DATA_W-2:0], din};
      if (active &&  lrck) sr_r <= {sr_r[DATA_W-2:0], din};
    end
  end

  // done survives an en drop so a frame completed just before still lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done      <= 1'b0;
      left      <= '0;
      right     <= '0;
      out_valid <= 1'b0;
    end else begin
      done <= last_bit;
      if (done) begin
        left      <= sr_l;
        right     <= sr_r;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_OVERRUN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end else if (ovr_clr) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end else if (overwrite) begin
      overrun <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end
`else
  logic unused_ovr;
  assign unused_ovr = overwrite;
`endif

endmodule

// File: tb/tb_i2s_rx_master.sv
// Randomised bench for i2s_rx_master: an ADC model drives DOUT for two configurations
// (24-bit left-justified and 16-bit I2S) and a frame-level model predicts the outputs.
module tb_i2s_rx_master;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, out_ready = 1'b1, ovr_clr = 1'b0;
  logic din_a = 1'b0, din_b = 1'b0;
  logic scki_a, bck_a, lrck_a, ov_a, scki_b, bck_b, lrck_b, ov_b;
  logic [23:0] left_a, right_a;
  logic [15:0] left_b, right_b;
`ifdef I2S_RX_OVERRUN_EN
  logic ovr_a, ovr_b;
  logic [7:0] dc_a, dc_b;
`endif

  always #5 clk = ~clk;

  i2s_rx_master #(.DATA_W(24), .SLOT_W(32), .BCK_DIV(4), .FMT(0)) u_dut_a (
    .clk(clk), .reset(reset), .en(en), .din(din_a), .scki(scki_a), .bck(bck_a),
    .lrck(lrck_a), .left(left_a), .right(right_a), .out_valid(ov_a), .out_ready(out_ready)
`ifdef I2S_RX_OVERRUN_EN
    , .overrun(ovr_a), .drop_count(dc_a), .ovr_clr(ovr_clr)
`endif
  );

  i2s_rx_master #(.DATA_W(16), .SLOT_W(32), .BCK_DIV(2), .FMT(1)) u_dut_b (
    .clk(clk), .reset(reset), .en(en), .din(din_b), .scki(scki_b), .bck(bck_b),
    .lrck(lrck_b), .left(left_b), .right(right_b), .out_valid(ov_b), .out_ready(out_ready)
`ifdef I2S_RX_OVERRUN_EN
    , .overrun(ovr_b), .drop_count(dc_b), .ovr_clr(ovr_clr)
`endif
  );

  // Per-config constants: frame length, BCK divider, slot width, format, data width,
  // and the frame position at which out_valid is first seen.
  int FR[2] = '{256, 128};
  int BD[2] = '{4, 2};
  int SW[2] = '{32, 32};
  int FM[2] = '{0, 1};
  int DW[2] = '{24, 16};
  int VL[2] = '{32*4 + (0+24-1)*4 + 2 + 2, 32*2 + (1+16-1)*2 + 1 + 2};

  int tc[2], drops[2], nfr[2];
  bit ev[2];
  logic [31:0] el[2], er[2], cl[2], cr[2];

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic din_for(input int i);
    int pos, ch, b;
    logic [31:0] s;
    pos = (tc[i] % FR[i]) / BD[i];
    ch  = pos / SW[i];
    b   = pos % SW[i];
    if (b >= FM[i] && b < FM[i] + DW[i]) begin
      s = (ch != 0) ? cr[i] : cl[i];
      return s[DW[i]-1-(b-FM[i])];
    end
    return 1'($urandom);
  endfunction

  task automatic obs(input int i, output logic b, output logic lr, output logic v,
                     output logic [31:0] l, output logic [31:0] r);
    if (i == 0) begin
      b = bck_a; lr = lrck_a; v = ov_a; l = 32'(left_a); r = 32'(right_a);
    end else begin
      b = bck_b; lr = lrck_b; v = ov_b; l = 32'(left_b); r = 32'(right_b);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      tc[i] = 0; ev[i] = 0; el[i] = '0; er[i] = '0; drops[i] = 0;
    end
  endtask

  task automatic check_outputs();
    logic b, lr, v;
    logic [31:0] l, r;
    string pre;
    for (int i = 0; i < 2; i++) begin
      pre = (i != 0) ? "b_" : "a_";
      obs(i, b, lr, v, l, r);
      chk({pre, "bck"},  32'(b),  32'((tc[i] % BD[i]) >= BD[i] / 2));
      chk({pre, "lrck"}, 32'(lr), 32'((tc[i] % FR[i]) >= FR[i] / 2));
      chk({pre, "valid"}, 32'(v), 32'(ev[i]));
      if (ev[i]) begin
        chk({pre, "left"},  l, el[i]);
        chk({pre, "right"}, r, er[i]);
      end
    end
`ifdef I2S_RX_OVERRUN_EN
    chk("a_drop_count", 32'(dc_a), 32'(drops[0]));
    chk("a_overrun",    32'(ovr_a), 32'(drops[0] != 0));
    chk("b_drop_count", 32'(dc_b), 32'(drops[1]));
    chk("b_overrun",    32'(ovr_b), 32'(drops[1] != 0));
`endif
  endtask

  // One clock: advance the model on the rising edge, check and drive on the falling edge.
  task automatic cycle();
    logic [31:0] mask;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        tc[i] = 0; ev[i] = 0; el[i] = '0; er[i] = '0; drops[i] = 0;
      end else begin
        if (tc[i] == VL[i] - 1) begin
          if (ev[i] && !out_ready) drops[i] = (drops[i] < 255) ? drops[i] + 1 : 255;
          ev[i] = 1; el[i] = cl[i]; er[i] = cr[i];
        end else if (ev[i] && out_ready) begin
          ev[i] = 0;
        end
        if (ovr_clr) drops[i] = 0;
        if (en && tc[i] == FR[i] - 1) begin
          nfr[i]++;
          if (nfr[i] >= 2) begin
            mask = (32'h1 << DW[i]) - 32'h1;
            cl[i] = $urandom & mask;
            cr[i] = $urandom & mask;
          end
        end
        tc[i] = en ? (tc[i] + 1) % FR[i] : 0;
      end
    end
    @(negedge clk);
    check_outputs();
    din_a = din_for(0);
    din_b = din_for(1);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic async_reset_check();
    #1 reset = 1'b1;
    #1;
    chk("rst_a_left", 32'(left_a), 32'h0);
    chk("rst_a_right", 32'(right_a), 32'h0);
    chk("rst_a_valid", 32'(ov_a), 32'h0);
    chk("rst_a_bck_lrck", {30'h0, bck_a, lrck_a}, 32'h0);
    chk("rst_b_valid", 32'(ov_b), 32'h0);
    model_reset();
  endtask

  initial begin
    cl[0] = 32'hABCDEF; cr[0] = 32'h123456;
    cl[1] = 32'h8001;   cr[1] = 32'h7FFE;
    nfr[0] = 0; nfr[1] = 0;
    model_reset();
    #1;
    chk("reset_a_valid", 32'(ov_a), 32'h0);
    chk("reset_a_left", 32'(left_a), 32'h0);
    chk("scki_follows_clk", 32'(scki_a), 32'(clk));
    run(3);
    reset = 1'b0;
    en = 1'b1;

    // Free-running capture with the consumer always ready.
    run(3 * 256);

    // Three frames land while the consumer stalls.
    for (int k = 0; k < 300 && tc[0] != 230; k++) cycle();
    chk("wait_a_230", 32'(tc[0] == 230), 32'h1);
    out_ready = 1'b0;
    run(3 * 256);
`ifdef I2S_RX_OVERRUN_EN
    chk("a_drop_plan", 32'(dc_a), 32'd2);
    chk("a_overrun_plan", 32'(ovr_a), 32'd1);
`endif
    out_ready = 1'b1;
    ovr_clr = 1'b1;
    cycle();
    ovr_clr = 1'b0;
    run(300);

    // Enable dropped in the middle of the left slot.
    for (int k = 0; k < 300 && tc[0] != 60; k++) cycle();
    chk("wait_a_60", 32'(tc[0] == 60), 32'h1);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(2 * 256 + 20);

    // Random backpressure and occasional overrun clears.
    for (int k = 0; k < 4 * 256; k++) begin
      out_ready = 1'($urandom);
      ovr_clr = ($urandom_range(0, 99) == 0);
      cycle();
    end
    ovr_clr = 1'b0;

    // Reset in the right slot with a frame pending.
    out_ready = 1'b0;
    for (int k = 0; k < 600 && !(tc[0] == 200 && ev[0]); k++) cycle();
    chk("wait_a_right_pending", 32'(tc[0] == 200 && ev[0]), 32'h1);
    async_reset_check();
    run(3);
    reset = 1'b0;
    out_ready = 1'b1;
    run(2 * 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
